// File: rtl/vape_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vape_pkg
// Description : Shared types and constants for the VAPE region guard: the
//               two-state monitor encoding and the bit positions of the
//               abort-cause vector.
// Revision    : 1.0 - initial release
// ============================================================================
package vape_pkg;

    typedef enum logic {
        ST_ABORT = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

    // Bit positions inside abort_cause
    localparam int CAUSE_CPU = 0;
    localparam int CAUSE_DMA = 1;
    localparam int CAUSE_ER  = 2;

endpackage
`default_nettype wire

// File: rtl/vape_range_hit.sv
`default_nettype none
// ============================================================================
// Module      : vape_range_hit
// Description : Combinational array of inclusive range comparators. Bit i of
//               o_hit is set when the strobe is active and i_addr lies inside
//               [min_i, max_i]. A region with min_i > max_i can never match.
// Ports       : i_en   - write strobe
//               i_addr - address under test
//               i_min  - packed lower bounds, region i at [i*ADDR_W +: ADDR_W]
//               i_max  - packed upper bounds, same packing
//               o_hit  - per-region hit vector
// Revision    : 1.0 - initial release
// ============================================================================
module vape_range_hit #(
    parameter int ADDR_W = 16,
    parameter int N_REG  = 2
) (
    input  logic                      i_en,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [N_REG*ADDR_W-1:0]   i_min,
    input  logic [N_REG*ADDR_W-1:0]   i_max,
    output logic [N_REG-1:0]          o_hit
);

    generate
        for (genvar gi = 0; gi < N_REG; gi++) begin : g_region
            logic [ADDR_W-1:0] w_min;
            logic [ADDR_W-1:0] w_max;

            assign w_min     = i_min[gi*ADDR_W +: ADDR_W];
            assign w_max     = i_max[gi*ADDR_W +: ADDR_W];
            // An inverted range fails one of the two compares for every address
            assign o_hit[gi] = i_en && (i_addr >= w_min) && (i_addr <= w_max);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vape_region_guard.sv
`default_nettype none
// ============================================================================
// Module      : vape_region_guard
// Description : Multi-region VAPE execution monitor. exec is high only while
//               the executable region was entered at its first instruction
//               and no metadata region, nor the ER bounds, changed since.
//               Latches the cause of the last abort and counts aborts.
// Ports       : clk          - system clock
//               reset        - asynchronous active-high reset
//               pc           - program counter
//               data_addr/en - CPU data-bus write tap
//               dma_addr/en  - DMA write tap
//               er_min/max   - executable region bounds (inclusive)
//               meta_min/max - packed metadata region bounds (inclusive)
//               exec         - ER execution valid
//               abort_cause  - {er_bound_change, dma_hit, cpu_hit}
//               abort_region - regions hit at the last abort
//               viol_cnt     - saturating EXEC->ABORT count
// Revision    : 1.0 - initial release
// ============================================================================
module vape_region_guard
    import vape_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int N_REG  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         pc,
    input  logic [ADDR_W-1:0]         data_addr,
    input  logic                      data_en,
    input  logic [ADDR_W-1:0]         dma_addr,
    input  logic                      dma_en,
    input  logic [ADDR_W-1:0]         er_min,
    input  logic [ADDR_W-1:0]         er_max,
    input  logic [N_REG*ADDR_W-1:0]   meta_min,
    input  logic [N_REG*ADDR_W-1:0]   meta_max,
    output logic                      exec,
    output logic [2:0]                abort_cause,
    output logic [N_REG-1:0]          abort_region,
    output logic [CNT_W-1:0]          viol_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [N_REG-1:0]  w_cpu_hit_v;
    logic [N_REG-1:0]  w_dma_hit_v;
    logic              w_cpu_hit;
    logic              w_dma_hit;
    logic              w_er_chg;
    logic              w_change;
    logic              w_entry;
    logic [2:0]        w_cause;

    logic [ADDR_W-1:0] r_prev_er_min;
    logic [ADDR_W-1:0] r_prev_er_max;
    logic              r_prev_vld;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_abort_evt;
    logic              w_enter_evt;

    logic [2:0]        r_abort_cause;
    logic [N_REG-1:0]  r_abort_region;
    logic [CNT_W-1:0]  r_viol_cnt;

    vape_range_hit #(
        .ADDR_W (ADDR_W),
        .N_REG  (N_REG)
    ) u_cpu_hit (
        .i_en   (data_en),
        .i_addr (data_addr),
        .i_min  (meta_min),
        .i_max  (meta_max),
        .o_hit  (w_cpu_hit_v)
    );

    vape_range_hit #(
        .ADDR_W (ADDR_W),
        .N_REG  (N_REG)
    ) u_dma_hit (
        .i_en   (dma_en),
        .i_addr (dma_addr),
        .i_min  (meta_min),
        .i_max  (meta_max),
        .o_hit  (w_dma_hit_v)
    );

    assign w_cpu_hit = |w_cpu_hit_v;
    assign w_dma_hit = |w_dma_hit_v;

    // prev_vld masks the first cycle after reset, when prev_er_* hold no history
    assign w_er_chg  = r_prev_vld &&
                       ((er_min != r_prev_er_min) || (er_max != r_prev_er_max));
    assign w_change  = w_cpu_hit || w_dma_hit || w_er_chg;
    assign w_entry   = (pc == er_min);

    always_comb begin
        w_cause            = 3'b000;
        w_cause[CAUSE_CPU] = w_cpu_hit;
        w_cause[CAUSE_DMA] = w_dma_hit;
        w_cause[CAUSE_ER]  = w_er_chg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_er_min <= '0;
            r_prev_er_max <= '0;
            r_prev_vld    <= 1'b0;
        end else begin
            r_prev_er_min <= er_min;
            r_prev_er_max <= er_max;
            r_prev_vld    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ABORT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Entry coinciding with a change is refused: the protected state is not
    // clean at the moment execution would start.
    always_comb begin
        w_state_nxt = r_state;
        w_abort_evt = 1'b0;
        w_enter_evt = 1'b0;
        case (r_state)
            ST_EXEC: begin
                if (w_change) begin
                    w_state_nxt = ST_ABORT;
                    w_abort_evt = 1'b1;
                end
            end
            ST_ABORT: begin
                if (w_entry && !w_change) begin
                    w_state_nxt = ST_EXEC;
                    w_enter_evt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_ABORT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_abort_cause  <= 3'b000;
            r_abort_region <= '0;
            r_viol_cnt     <= '0;
        end else if (w_abort_evt) begin
            r_abort_cause  <= w_cause;
            r_abort_region <= w_cpu_hit_v | w_dma_hit_v;
            if (r_viol_cnt != c_cnt_max) begin
                r_viol_cnt <= r_viol_cnt + CNT_W'(1);
            end
        end else if (w_enter_evt) begin
            r_abort_cause  <= 3'b000;
            r_abort_region <= '0;
        end
    end

    assign exec         = (r_state == ST_EXEC);
    assign abort_cause  = r_abort_cause;
    assign abort_region = r_abort_region;
    assign viol_cnt     = r_viol_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vape_region_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_vape_region_guard
// Description : Self-checking bench for vape_region_guard. Two instances share
//               one stimulus stream: CNT_W=8 and CNT_W=2 (saturation). An
//               abstract model predicts every output; directed checks pin it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vape_region_guard;

    localparam int AW = 16;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] pc = '0;
    logic [AW-1:0] data_addr = '0;
    logic          data_en = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic          dma_en = 1'b0;
    logic [AW-1:0] er_min = 16'h1234;
    logic [AW-1:0] er_max = 16'h5678;
    logic [NR*AW-1:0] meta_min = {16'h0200, 16'h0140};
    logic [NR*AW-1:0] meta_max = {16'h0210, 16'h0160};

    logic          exec_a, exec_b;
    logic [2:0]    cause_a, cause_b;
    logic [NR-1:0] region_a, region_b;
    logic [7:0]    cnt_a;
    logic [1:0]    cnt_b;

    vape_region_guard #(.ADDR_W(AW), .N_REG(NR), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .pc(pc),
        .data_addr(data_addr), .data_en(data_en),
        .dma_addr(dma_addr), .dma_en(dma_en),
        .er_min(er_min), .er_max(er_max),
        .meta_min(meta_min), .meta_max(meta_max),
        .exec(exec_a), .abort_cause(cause_a),
        .abort_region(region_a), .viol_cnt(cnt_a)
    );

    vape_region_guard #(.ADDR_W(AW), .N_REG(NR), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .pc(pc),
        .data_addr(data_addr), .data_en(data_en),
        .dma_addr(dma_addr), .dma_en(dma_en),
        .er_min(er_min), .er_max(er_max),
        .meta_min(meta_min), .meta_max(meta_max),
        .exec(exec_b), .abort_cause(cause_b),
        .abort_region(region_b), .viol_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: what the outputs must be after each edge
    // ------------------------------------------------------------------
    bit          m_exec = 0;
    bit [2:0]    m_cause = 0;
    bit [NR-1:0] m_region = 0;
    int          m_cnt8 = 0;
    int          m_cnt2 = 0;
    bit          m_hist = 0;
    int          m_old_min = 0;
    int          m_old_max = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_exec = 0; m_cause = 0; m_region = 0;
            m_cnt8 = 0; m_cnt2 = 0; m_hist = 0;
        end else begin
            bit [NR-1:0] cv, dv;
            bit erc, anychg;
            for (int i = 0; i < NR; i++) begin
                int lo, hi;
                lo = int'(meta_min[i*AW +: AW]);
                hi = int'(meta_max[i*AW +: AW]);
                cv[i] = data_en && lo <= int'(data_addr) && int'(data_addr) <= hi;
                dv[i] = dma_en  && lo <= int'(dma_addr)  && int'(dma_addr)  <= hi;
            end
            erc    = m_hist && (int'(er_min) != m_old_min || int'(er_max) != m_old_max);
            anychg = (cv != 0) || (dv != 0) || erc;
            if (m_exec && anychg) begin
                m_exec   = 0;
                m_cause  = {erc, dv != 0, cv != 0};
                m_region = cv | dv;
                m_cnt8   = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2   = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
            end else if (!m_exec && pc == er_min && !anychg) begin
                m_exec = 1; m_cause = 0; m_region = 0;
            end
            m_old_min = int'(er_min);
            m_old_max = int'(er_max);
            m_hist    = 1;
        end
    end

    always @(negedge clk) begin
        chk("m_exec",    {31'd0, exec_a},   {31'd0, m_exec});
        chk("m_cause",   {29'd0, cause_a},  {29'd0, m_cause});
        chk("m_region",  {30'd0, region_a}, {30'd0, m_region});
        chk("m_cnt",     {24'd0, cnt_a},    m_cnt8);
        chk("m_exec_s",  {31'd0, exec_b},   {31'd0, m_exec});
        chk("m_cause_s", {29'd0, cause_b},  {29'd0, m_cause});
        chk("m_cnt_s",   {30'd0, cnt_b},    m_cnt2);
    end

    // ------------------------------------------------------------------
    // Directed stimulus; inputs change 1 time unit after each rising edge
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        pc = '0; data_en = 0; dma_en = 0;
    endtask

    task automatic enter();
        quiet();
        pc = 16'hE000;
        tick();
        chk("enter_exec", {31'd0, exec_a}, 32'd1);
        quiet();
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a);
        quiet(); data_en = 1; data_addr = a;
        tick();
        quiet();
    endtask

    initial begin
        tick(); tick();
        chk("rst_exec",  {31'd0, exec_a},   32'd0);
        chk("rst_cause", {29'd0, cause_a},  32'd0);
        chk("rst_cnt",   {24'd0, cnt_a},    32'd0);
        reset = 0;
        tick();                              // arbitrary ER, no history yet
        chk("first_cyc_cnt", {24'd0, cnt_a}, 32'd0);
        er_min = 16'hE000; er_max = 16'h00FF | 16'hE000;
        tick();                              // ER change while in ABORT
        chk("abort_chg_cnt", {24'd0, cnt_a}, 32'd0);

        enter();
        chk("enter_cnt", {24'd0, cnt_a}, 32'd0);

        cpu_wr(16'h0150);
        chk("cpu_exec",   {31'd0, exec_a},   32'd0);
        chk("cpu_cause",  {29'd0, cause_a},  32'd1);
        chk("cpu_region", {30'd0, region_a}, 32'd1);
        chk("cpu_cnt",    {24'd0, cnt_a},    32'd1);

        enter();
        data_en = 1; data_addr = 16'h0140; dma_en = 1; dma_addr = 16'h0200;
        tick(); quiet();
        chk("both_cause",  {29'd0, cause_a},  32'd3);
        chk("both_region", {30'd0, region_a}, 32'd3);

        enter();
        cpu_wr(16'h0160);
        chk("hi_edge_exec", {31'd0, exec_a}, 32'd0);

        enter();
        cpu_wr(16'h013F);
        chk("below_exec", {31'd0, exec_a}, 32'd1);
        cpu_wr(16'h0161);
        chk("above_exec", {31'd0, exec_a}, 32'd1);

        meta_min[31:16] = 16'h0300; meta_max[31:16] = 16'h0200;
        cpu_wr(16'h0200); cpu_wr(16'h0250); cpu_wr(16'h0300);
        chk("inverted_exec", {31'd0, exec_a}, 32'd1);

        er_max = 16'hE100;
        tick();
        chk("er_exec",  {31'd0, exec_a},  32'd0);
        chk("er_cause", {29'd0, cause_a}, 32'd4);
        chk("er_cnt",   {24'd0, cnt_a},   32'd4);
        chk("sat_cnt",  {30'd0, cnt_b},   32'd3);

        pc = 16'hE000; data_en = 1; data_addr = 16'h0150;
        tick(); quiet();
        chk("entry_chg_exec", {31'd0, exec_a}, 32'd0);
        chk("entry_chg_cnt",  {24'd0, cnt_a},  32'd4);

        enter();
        quiet(); dma_en = 1; dma_addr = 16'h0145;
        tick(); quiet();
        chk("dma_cause", {29'd0, cause_a}, 32'd2);
        chk("dma_cnt",   {24'd0, cnt_a},   32'd5);
        chk("sat_hold",  {30'd0, cnt_b},   32'd3);

        enter();
        #2 reset = 1;
        #1;
        chk("async_exec", {31'd0, exec_a}, 32'd0);
        chk("async_cnt",  {24'd0, cnt_a},  32'd0);
        tick();
        reset = 0;
        tick();
        chk("no_reentry", {31'd0, exec_a}, 32'd0);
        enter();

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vape_region_guard.md
# vape_region_guard

Parametrised successor to the single-region VAPE execution monitor. It watches N_REG independent metadata regions, the CPU data bus, the DMA bus and the executable-region bounds themselves. It drives `exec` high only while the executable region (ER) has been entered at its first instruction and no protected state has changed since. It sits beside the other VRASED hardware monitors, takes the same `pc`/bus taps, and adds a latched abort cause and a saturating violation counter for the attestation report.

## Interface
- ADDR_W, 16, width of pc, data, DMA and bound addresses
- N_REG, 2, number of watched metadata regions (1..8)
- CNT_W, 8, width of violation counter
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pc  in  ADDR_W  current program counter
- data_addr  in  ADDR_W  CPU data-bus address
- data_en  in  1  CPU data write strobe
- dma_addr  in  ADDR_W  DMA address
- dma_en  in  1  DMA write strobe
- er_min, er_max  in  ADDR_W each  ER bounds, inclusive
- meta_min, meta_max  in  N_REG*ADDR_W each  packed region bounds, region i at bits [i*ADDR_W +: ADDR_W], inclusive
- exec  out  1  ER execution is valid
- abort_cause  out  3  {er_bound_change, dma_hit, cpu_hit} latched at the last EXEC->ABORT
- abort_region  out  N_REG  regions hit at the last EXEC->ABORT
- viol_cnt  out  CNT_W  count of EXEC->ABORT transitions, saturating

## Operation
- Hit vectors, per region i:
  - cpu_hit_v[i] = data_en && meta_min_i <= data_addr <= meta_max_i.
  - dma_hit_v[i] is the same test on dma_en/dma_addr.
  - cpu_hit = |cpu_hit_v and dma_hit = |dma_hit_v.
- A region with meta_min_i > meta_max_i never matches.
- ER bound change:
  - prev_er_min/prev_er_max registers load er_min/er_max every cycle.
  - prev_vld is cleared by reset and set after the first clock.
  - er_chg = prev_vld && (er_min != prev_er_min || er_max != prev_er_max).
  - There is no spurious change on the first cycle after reset.
- change = cpu_hit || dma_hit || er_chg.
- entry = (pc == er_min).
- State machine with two states, ABORT and EXEC; reset state is ABORT.
  - EXEC & change -> ABORT:
    - latch abort_cause = {er_chg, dma_hit, cpu_hit} and abort_region = cpu_hit_v | dma_hit_v;
    - increment viol_cnt, saturating at all-ones.
  - ABORT & entry & !change -> EXEC:
    - clear abort_cause and abort_region.
  - In every other case the state holds, and so do abort_cause, abort_region and viol_cnt.
- exec = (state == EXEC), driven from a flop with no combinational path from the inputs.
- A change observed while in ABORT is neither counted nor latched.
- Entry and change in the same cycle: the block stays in ABORT, nothing is latched, and the counter does not move.
- Simultaneous CPU and DMA hits on different regions: both cause bits are set and both region bits are set.
- The block does not monitor pc leaving the ER. The exit/atomicity monitor owns that check.

## Timing
- All outputs are registered.
- Reset values: exec=0, abort_cause=0, abort_region=0, viol_cnt=0; prev_er_* are don't-care while prev_vld=0.
- Latency, entry: pc==er_min sampled at edge k gives exec=1 after edge k.
- Latency, violation: a write sampled at edge k gives exec=0 after edge k, with the cause valid in the same cycle.
- A bound change at edge k (new value first sampled at k, old value held in prev) aborts after edge k.
- Reset asserted mid-EXEC forces ABORT and clears all outputs immediately and asynchronously. Re-entry after release requires a fresh pc==er_min.
- viol_cnt at all-ones stays there on further violations. State and cause still update.

## Structure
- Package vape_pkg holds:
  - the state encoding (ABORT=1'b0... as localparam enum);
  - the cause bit indices CAUSE_CPU=0, CAUSE_DMA=1, CAUSE_ER=2.
- Sub-module vape_range_hit (ADDR_W, N_REG): combinational range-compare array, instantiated twice (CPU, DMA), returns the hit vector.
- Top module holds the FSM, the previous-ER registers, the cause latch and the counter.

## Test plan
- ADDR_W=16, N_REG=2, er_min=0xE000, meta0=0x0140..0x0160:
  - reset, then pc=0xE000 -> exec=1 one cycle later, viol_cnt=0.
- In EXEC:
  - data_en=1, data_addr=0x0150 -> exec=0 next cycle, abort_cause=3'b001, abort_region=2'b01, viol_cnt=1.
  - Simultaneously DMA writes region1 (0x0200..0x0210) at 0x0200 while the CPU writes 0x0140 -> abort_cause=3'b011, abort_region=2'b11.
- Boundary hits:
  - writes at 0x0140 and at 0x0160 each abort.
  - writes at 0x013F and at 0x0161 do not abort.
  - a region with min=0x0300, max=0x0200 never aborts.
- In EXEC, er_max changes 0xE0FF->0xE100 -> abort with abort_cause=3'b100. The first cycle after reset with arbitrary ER values -> no abort and no count.
- Counter and reset:
  - with CNT_W=2, four violation/re-entry cycles -> viol_cnt sticks at 3;
  - pc=0xE000 together with data_en at 0x0150 -> exec stays 0;
  - asserting reset mid-EXEC -> exec=0 asynchronously.
